// File: rtl/core_intc_pkg.sv
// -----------------------------------------------------------------------------
// core_intc_pkg
//   Shared definitions for the core interrupt controller:
//     - reg_t         : register data word seen on the register port
//     - intc_state_t  : request/service state of the controller
//     - INTC_*        : register offsets decoded from reg_sel
//     - stat_word()   : packs the STAT register read value
// -----------------------------------------------------------------------------
package core_intc_pkg;

  // Wide enough for the largest supported source count (16).
  localparam int REG_W = 16;

  typedef logic [REG_W-1:0] reg_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } intc_state_t;

  localparam logic [1:0] INTC_PEND = 2'd0;
  localparam logic [1:0] INTC_MASK = 2'd1;
  localparam logic [1:0] INTC_EDGE = 2'd2;
  localparam logic [1:0] INTC_STAT = 2'd3;

  // STAT reads back {in_service, irq_id}, zero-extended.
  function automatic reg_t stat_word(input logic busy, input logic [3:0] id);
    return reg_t'({busy, id});
  endfunction

endpackage

// File: rtl/core_intc_prio.sv
// -----------------------------------------------------------------------------
// core_intc_prio
//   Fixed-priority encoder: the lowest set index of the active vector wins.
//   Purely combinational.
//
// Ports
//   active  in  NSRC  eligible sources (pending & mask)
//   valid   out 1     at least one source is eligible
//   id      out 4     index of the winning source (0 when none)
// -----------------------------------------------------------------------------
module core_intc_prio #(
  parameter int NSRC = 8
) (
  input  logic [NSRC-1:0] active,
  output logic            valid,
  output logic [3:0]      id
);

  // Scan from the top down so the lowest set index is the last one written.
  // NOTE: every output gets a default before the loop; without it the
  // no-source case would leave valid/id unassigned and infer a latch.
  always_comb begin
    valid = 1'b0;
    id    = 4'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (active[i]) begin
        valid = 1'b1;
        id    = 4'(i);
      end
    end
  end

endmodule

// File: rtl/core_intc.sv
// -----------------------------------------------------------------------------
// core_intc
//   Small interrupt controller for a CPU core. Each raw source is
//   synchronised, captured as either a rising-edge latch or a level, masked,
//   and prioritised (lowest index wins). A three-state sequencer raises irq,
//   hands the winning id to the exception unit on irq_ack and then waits for
//   an end-of-interrupt write before it will request again.
//
// Ports
//   clk         in   1      core clock
//   rst         in   1      asynchronous, active-low reset
//   src         in   NSRC   raw interrupt lines (asynchronous to clk)
//   reg_sel     in   2      register select (PEND/MASK/EDGE/STAT)
//   reg_we      in   1      register write strobe
//   reg_wdata   in   reg_t  register write data
//   reg_rdata   out  reg_t  register read data (combinational on reg_sel)
//   irq         out  1      interrupt request, high while requesting
//   irq_ack     in   1      acknowledge from the exception unit
//   irq_id      out  4      id of the source taken into service
//   in_service  out  1      a source is currently being serviced
//
// Register map
//   PEND  read pending; write 1 clears edge-mode bits (level bits ignore it)
//   MASK  read/write, 1 = source enabled
//   EDGE  read/write, 1 = rising-edge latched, 0 = level
//   STAT  read {in_service, irq_id}; any write is end-of-interrupt
// -----------------------------------------------------------------------------
module core_intc
  import core_intc_pkg::*;
#(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NSRC-1:0] src,
  input  logic [1:0]      reg_sel,
  input  logic            reg_we,
  input  reg_t            reg_wdata,
  output reg_t            reg_rdata,
  output logic            irq,
  input  logic            irq_ack,
  output logic [3:0]      irq_id,
  output logic            in_service
);

  // ---------------------------------------------------------------------------
  // Input synchroniser and edge history
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] sync_meta;   // first flop, may go metastable
  logic [NSRC-1:0] sync_line;   // synchronised source lines
  logic [NSRC-1:0] sync_prev;   // sync_line one cycle earlier, for edge detect

  // Because sync_prev also resets to 0, a line already high at reset release
  // is still seen as a clean 0->1 transition once it reaches sync_line.
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbours; a blocking = here would collapse
  // the two-flop synchroniser into a single stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta <= '0;
      sync_line <= '0;
      sync_prev <= '0;
    end else begin
      sync_meta <= src;
      sync_line <= sync_meta;
      sync_prev <= sync_line;
    end
  end

  logic [NSRC-1:0] rise;
  assign rise = sync_line & ~sync_prev;

  // ---------------------------------------------------------------------------
  // Register write decode
  // ---------------------------------------------------------------------------
  logic wr_pend;
  logic wr_mask;
  logic wr_edge;
  logic eoi;

  assign wr_pend = reg_we && (reg_sel == INTC_PEND);
  assign wr_mask = reg_we && (reg_sel == INTC_MASK);
  assign wr_edge = reg_we && (reg_sel == INTC_EDGE);
  assign eoi     = reg_we && (reg_sel == INTC_STAT);

  // Only the low NSRC bits of write data carry meaning.
  if (NSRC < REG_W) begin : g_unused_wdata
    logic unused_wdata;
    assign unused_wdata = ^reg_wdata[REG_W-1:NSRC];
  end

  // ---------------------------------------------------------------------------
  // Pending / mask / edge-mode state
  // ---------------------------------------------------------------------------
  logic [NSRC-1:0] pend;
  logic [NSRC-1:0] mask;
  logic [NSRC-1:0] edge_mode;
  logic [NSRC-1:0] pend_clr;
  logic [NSRC-1:0] pend_next;

  logic [NSRC-1:0] active;
  logic            prio_valid;
  logic [3:0]      prio_id;
  logic            any_active;

  intc_state_t     state;
  logic            take;        // acknowledge accepted this cycle

  assign active     = pend & mask;
  assign any_active = |active;
  assign take       = (state == REQ) && irq_ack;

  core_intc_prio #(
    .NSRC (NSRC)
  ) u_prio (
    .active (active),
    .valid  (prio_valid),
    .id     (prio_id)
  );

  // Edge bits: hold until cleared by W1C or by being taken into service;
  // a new rising edge in the same cycle overrides either clear.
  // Level bits: simply follow the synchronised line.
  always_comb begin
    pend_clr = '0;
    if (wr_pend) begin
      pend_clr = reg_wdata[NSRC-1:0];
    end
    if (take && prio_valid) begin
      pend_clr = pend_clr | (NSRC'(1) << prio_id);
    end
    pend_next = (edge_mode & ((pend & ~pend_clr) | rise)) |
                (~edge_mode & sync_line);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend      <= '0;
      mask      <= '0;
      edge_mode <= '0;
    end else begin
      pend <= pend_next;
      if (wr_mask) mask      <= reg_wdata[NSRC-1:0];
      if (wr_edge) edge_mode <= reg_wdata[NSRC-1:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Request / service sequencer
  //   IDLE    -> REQ      any eligible source
  //   REQ     -> SERVICE  irq_ack (id captured even if eligibility just fell)
  //   REQ     -> IDLE     nothing eligible any more and no ack
  //   SERVICE -> IDLE     EOI write
  // irq is registered alongside the state so it is high exactly in REQ.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= 4'd0;
      in_service <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_active) begin
            state <= REQ;
            irq   <= 1'b1;
          end
        end
        REQ: begin
          if (irq_ack) begin
            state      <= SERVICE;
            irq        <= 1'b0;
            irq_id     <= prio_id;   // 0 when nothing is eligible
            in_service <= 1'b1;
          end else if (!any_active) begin
            state <= IDLE;
            irq   <= 1'b0;
          end
        end
        SERVICE: begin
          if (eoi) begin
            state      <= IDLE;
            in_service <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          irq        <= 1'b0;
          in_service <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------------
  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      INTC_PEND: reg_rdata = reg_t'(pend);
      INTC_MASK: reg_rdata = reg_t'(mask);
      INTC_EDGE: reg_rdata = reg_t'(edge_mode);
      INTC_STAT: reg_rdata = stat_word(in_service, irq_id);
      default:   reg_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_core_intc.sv
// -----------------------------------------------------------------------------
// tb_core_intc
//   Directed scenarios followed by random traffic for core_intc. A
//   transaction-level reference model (source history, pending/mask/edge
//   words and a request/service mode) predicts every output after each
//   clock edge.
// -----------------------------------------------------------------------------
module tb_core_intc;
  import core_intc_pkg::*;

  localparam int NSRC = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic [NSRC-1:0] src;
  logic [1:0]      reg_sel;
  logic            reg_we;
  reg_t            reg_wdata;
  reg_t            reg_rdata;
  logic            irq;
  logic            irq_ack;
  logic [3:0]      irq_id;
  logic            in_service;

  always #5 clk = ~clk;

  core_intc #(.NSRC(NSRC)) dut (
    .clk        (clk),
    .rst        (rst),
    .src        (src),
    .reg_sel    (reg_sel),
    .reg_we     (reg_we),
    .reg_wdata  (reg_wdata),
    .reg_rdata  (reg_rdata),
    .irq        (irq),
    .irq_ack    (irq_ack),
    .irq_id     (irq_id),
    .in_service (in_service)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  localparam int M_IDLE = 0, M_REQ = 1, M_SERVICE = 2;

  logic [7:0] h1, h2, h3;          // src sampled at the last three clock edges
  logic [7:0] m_pend, m_mask, m_edge;
  int         m_mode;
  logic       m_irq, m_insvc;
  logic [3:0] m_id;

  task automatic model_reset();
    h1 = '0; h2 = '0; h3 = '0;
    m_pend = '0; m_mask = '0; m_edge = '0;
    m_mode = M_IDLE; m_irq = 1'b0; m_insvc = 1'b0; m_id = 4'd0;
  endtask

  // Called right after a rising edge, while inputs still hold their
  // pre-edge values. A source line reaches the controller two samples late.
  task automatic model_edge();
    logic [7:0] act, lowbit, w1c, ack_clr, rise, line;
    logic [7:0] n_pend, n_mask, n_edge;
    line    = h2;
    rise    = h2 & ~h3;
    act     = m_pend & m_mask;
    lowbit  = act & (~act + 8'd1);
    w1c     = (reg_we && reg_sel == INTC_PEND) ? reg_wdata[7:0] : 8'h00;
    ack_clr = 8'h00;
    case (m_mode)
      M_IDLE: if (act != 0) begin m_mode = M_REQ; m_irq = 1'b1; end
      M_REQ: begin
        if (irq_ack) begin
          m_mode  = M_SERVICE;
          m_irq   = 1'b0;
          m_insvc = 1'b1;
          m_id    = (act != 0) ? 4'($clog2(lowbit)) : 4'd0;
          ack_clr = lowbit;
        end else if (act == 0) begin
          m_mode = M_IDLE;
          m_irq  = 1'b0;
        end
      end
      default: if (reg_we && reg_sel == INTC_STAT) begin
        m_mode = M_IDLE; m_insvc = 1'b0;
      end
    endcase
    n_pend = (m_edge & ((m_pend & ~(w1c | ack_clr)) | rise)) | (~m_edge & line);
    n_mask = (reg_we && reg_sel == INTC_MASK) ? reg_wdata[7:0] : m_mask;
    n_edge = (reg_we && reg_sel == INTC_EDGE) ? reg_wdata[7:0] : m_edge;
    m_pend = n_pend; m_mask = n_mask; m_edge = n_edge;
    h3 = h2; h2 = h1; h1 = src;
  endtask

  function automatic reg_t model_rdata(input logic [1:0] sel);
    case (sel)
      INTC_PEND: return {8'h00, m_pend};
      INTC_MASK: return {8'h00, m_mask};
      INTC_EDGE: return {8'h00, m_edge};
      default:   return {11'd0, m_insvc, m_id};
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Checking and stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("irq",        16'(irq),        16'(m_irq));
    check("irq_id",     16'(irq_id),     16'(m_id));
    check("in_service", 16'(in_service), 16'(m_insvc));
    check("reg_rdata",  reg_rdata,       model_rdata(reg_sel));
  endtask

  task automatic step(input logic ack, input logic we, input logic [1:0] sel,
                      input logic [15:0] wd);
    irq_ack = ack; reg_we = we; reg_sel = sel; reg_wdata = wd;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic step_idle();
    step(1'b0, 1'b0, reg_sel, 16'h0000);
  endtask

  task automatic step_rd(input logic [1:0] sel);
    step(1'b0, 1'b0, sel, 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b0; src = '0; irq_ack = 1'b0; reg_we = 1'b0;
    reg_sel = INTC_PEND; reg_wdata = '0;
    model_reset();
    #12;
    check("rst_irq", 16'(irq), 16'h0);
    check("rst_irq_id", 16'(irq_id), 16'h0);
    check("rst_in_service", 16'(in_service), 16'h0);
    for (int s = 0; s < 4; s++) begin
      reg_sel = 2'(s);
      #1;
      check("rst_reg", reg_rdata, 16'h0000);
    end
    @(negedge clk);
    rst = 1'b1;

    // Edge source 2: one-cycle pulse, request, acknowledge
    step(1'b0, 1'b1, INTC_MASK, 16'h0004);
    step(1'b0, 1'b1, INTC_EDGE, 16'h0004);
    src = 8'h04; step_idle();
    src = 8'h00; step_idle(); step_idle();
    check("s1_irq_early", 16'(irq), 16'h0);
    step_idle();
    check("s1_irq_3cyc", 16'(irq), 16'h1);
    step(1'b1, 1'b0, INTC_PEND, 16'h0000);
    check("s1_id", 16'(irq_id), 16'h2);
    check("s1_pend2_clr", reg_rdata, 16'h0000);
    check("s1_in_service", 16'(in_service), 16'h1);
    step(1'b0, 1'b1, INTC_STAT, 16'h0000);
    check("s1_eoi", 16'(in_service), 16'h0);

    // Level sources 1 and 5 together: priority, EOI, then the next one
    step(1'b0, 1'b1, INTC_EDGE, 16'h0000);
    step(1'b0, 1'b1, INTC_MASK, 16'h00FF);
    src = 8'h22;
    repeat (4) step_idle();
    check("s2_irq", 16'(irq), 16'h1);
    step(1'b1, 1'b0, INTC_STAT, 16'h0000);
    check("s2_id1", 16'(irq_id), 16'h1);
    check("s2_stat", reg_rdata, 16'h0011);
    src = 8'h20;
    repeat (4) step_idle();
    step(1'b0, 1'b1, INTC_STAT, 16'h0000);
    check("s2_irq_after_eoi", 16'(irq), 16'h0);
    step_idle();
    check("s2_irq_2cyc", 16'(irq), 16'h1);
    step(1'b1, 1'b0, INTC_STAT, 16'h0000);
    check("s2_id5", 16'(irq_id), 16'h5);
    check("s2_stat5", reg_rdata, 16'h0015);

    // Edge event on source 0 while in service: pends but no irq until EOI
    src = 8'h00;
    step(1'b0, 1'b1, INTC_EDGE, 16'h0001);
    src = 8'h01; step_idle();
    src = 8'h00;
    repeat (3) step_idle();
    step_rd(INTC_PEND);
    check("s3_irq_held", 16'(irq), 16'h0);
    check("s3_pend0", reg_rdata, 16'h0001);
    step(1'b0, 1'b1, INTC_STAT, 16'h0000);
    check("s3_irq_1cyc", 16'(irq), 16'h0);
    step_idle();
    check("s3_irq_2cyc", 16'(irq), 16'h1);
    step(1'b1, 1'b0, INTC_STAT, 16'h0000);
    check("s3_id0", 16'(irq_id), 16'h0);
    step(1'b0, 1'b1, INTC_STAT, 16'h0000);

    // Masking everything while requesting withdraws the request
    src = 8'h01; step_idle();
    src = 8'h00;
    repeat (3) step_idle();
    check("s4_irq", 16'(irq), 16'h1);
    step(1'b0, 1'b1, INTC_MASK, 16'h0000);
    step_rd(INTC_PEND);
    check("s4_irq_dropped", 16'(irq), 16'h0);
    check("s4_pend_kept", reg_rdata, 16'h0001);
    step_idle();
    check("s4_idle", 16'(irq), 16'h0);

    // Reset while in service with PEND = 0x81
    step(1'b0, 1'b1, INTC_EDGE, 16'h0000);
    step(1'b0, 1'b1, INTC_MASK, 16'h00FF);
    src = 8'h81;
    repeat (4) step_idle();
    step(1'b1, 1'b0, INTC_PEND, 16'h0000);
    step_idle();
    check("s5_svc", 16'(in_service), 16'h1);
    check("s5_pend", reg_rdata, 16'h0081);
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    check("s5_rst_irq", 16'(irq), 16'h0);
    check("s5_rst_svc", 16'(in_service), 16'h0);
    check("s5_rst_pend", reg_rdata, 16'h0000);
    reg_sel = INTC_MASK;
    #1;
    check("s5_rst_mask", reg_rdata, 16'h0000);
    src = 8'h00;
    @(negedge clk);
    rst = 1'b1;

    // W1C of PEND[3] coinciding with a new edge on source 3: set wins
    step(1'b0, 1'b1, INTC_EDGE, 16'h0008);
    src = 8'h08; step_idle();
    src = 8'h00;
    repeat (3) step_rd(INTC_PEND);
    check("s6_pend3", reg_rdata, 16'h0008);
    src = 8'h08; step_idle();
    src = 8'h00; step_idle();
    step(1'b0, 1'b1, INTC_PEND, 16'h0008);
    check("s6_set_wins", reg_rdata, 16'h0008);
    step(1'b0, 1'b1, INTC_PEND, 16'h0008);
    check("s6_w1c", reg_rdata, 16'h0000);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       r_ack, r_we;
      logic [1:0] r_sel;
      if ($urandom_range(0, 3) == 0) src = 8'($urandom);
      r_ack = ($urandom_range(0, 2) == 0);
      r_we  = ($urandom_range(0, 4) == 0);
      r_sel = 2'($urandom);
      step(r_ack, r_we, r_sel, 16'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
